booth_mult: RTL
===============

BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 4 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock, rising edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication, honoured only in IDLE.
REQ-005 The block SHALL have port inbus, input, WIDTH bits: operand input bus.
REQ-006 The block SHALL have port outbus, output, WIDTH bits: product output bus.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-008 The block SHALL have port out_valid, output, 1 bit: outbus carries product data.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the last product word.

Function
REQ-010 The block SHALL compute the signed two's-complement product M*Q (radix-2 Booth) as a 2*WIDTH-bit result.
REQ-011 The FSM SHALL have states IDLE, LOAD_M, LOAD_Q, ADD, SHIFT, OUT_HI, OUT_LO.
REQ-012 IDLE SHALL go to LOAD_M on the edge where start=1, and otherwise stay in IDLE.
REQ-013 start SHALL be ignored in every state other than IDLE.
REQ-014 On the edge leaving LOAD_M, the block SHALL capture M <= inbus.
REQ-015 On the edge leaving LOAD_Q, the block SHALL load Q <= inbus, A <= 0, Q_1 <= 0 and count <= 0.
REQ-016 LOAD_Q SHALL always go to ADD.
REQ-017 A SHALL be WIDTH+1 bits; M SHALL be sign-extended to WIDTH+1 bits for add and subtract; arithmetic SHALL be modulo 2^(WIDTH+1).
REQ-018 The ADD state SHALL act on {Q[0],Q_1}: 01 -> A <= A+M; 10 -> A <= A-M; 00 or 11 -> A unchanged.
REQ-019 ADD SHALL always go to SHIFT.
REQ-020 The SHIFT state SHALL perform an arithmetic right shift of {A,Q,Q_1} by one, with A's MSB replicated, and SHALL increment count.
REQ-021 SHIFT SHALL go to OUT_HI when count was WIDTH-1 before the increment, and otherwise go to ADD.
REQ-022 OUT_HI SHALL drive outbus = A[WIDTH-1:0] with out_valid=1, then go to OUT_LO.
REQ-023 OUT_LO SHALL drive outbus = Q with out_valid=1 and done=1, then go to IDLE.
REQ-024 outbus SHALL be 0 whenever out_valid=0.
REQ-025 Latency: with start sampled at edge 0, OUT_HI SHALL occupy cycle 2*WIDTH+3 and OUT_LO cycle 2*WIDTH+4; for WIDTH=8 these are cycles 19 and 20.
REQ-026 The block SHALL accept a new start in the first IDLE cycle after OUT_LO, with no dead cycle.
REQ-027 M, Q and A SHALL retain their values in IDLE after completion.

Reset
REQ-028 While reset=0, and at any point including mid-operation, state SHALL be IDLE and A, Q, Q_1, M and count SHALL be 0.
REQ-029 While reset=0, outbus SHALL be 0 and busy, out_valid and done SHALL be 0.
REQ-030 An operation interrupted by reset SHALL be discarded with no output produced.
REQ-031 After reset is released, the block SHALL require a fresh start to begin an operation.

Structure
REQ-032 Package booth_pkg SHALL hold the state enumeration, the WIDTH default and the COUNT_W = clog2(WIDTH) constant.
REQ-033 The iteration counter SHALL be a separate sub-module, iter_cnt, with clear, increment-enable and terminal-count output, and asynchronous active-low reset.
REQ-034 The A/Q register update SHALL be written as load-or-shift enables, so a later swap to the team's shift-register cell needs no FSM change.

Verification
REQ-035 The bench SHALL cover: M=5, Q=3 (WIDTH=8) -> OUT_HI 0x00, OUT_LO 0x0F, done in cycle 20.
REQ-036 The bench SHALL cover: M=-7 (0xF9), Q=3 -> 0xFF then 0xEB.
REQ-037 The bench SHALL cover: M=-128, Q=-128 -> 0x40 then 0x00, and M=-128, Q=127 -> 0xC0 then 0x80, exercising the extended A.
REQ-038 The bench SHALL cover: start held high continuously through an operation -> exactly one result; a second operation starts in the first IDLE cycle after OUT_LO.
REQ-039 The bench SHALL cover: reset pulled low during the 5th SHIFT -> busy=0, outbus=0 immediately, and no done pulse.
REQ-040 The bench SHALL cover: 200 random operand pairs checked against a signed reference product -> all match, with busy high for exactly 2*WIDTH+4 cycles each.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: state encoding,
// default operand width and iteration-counter sizing.
package booth_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int COUNT_W       = $clog2(WIDTH_DEFAULT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    ADD    = 3'd3,
    SHIFT  = 3'd4,
    OUT_HI = 3'd5,
    OUT_LO = 3'd6
  } state_t;

  // Counter width for an arbitrary operand width; never narrower than one bit.
  function automatic int count_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/iter_cnt.sv
// Booth iteration counter: synchronous clear, increment enable and a
// terminal-count flag raised while the count sits on the final iteration.
module iter_cnt #(
  parameter int LIMIT = 8,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] count;

  // Iteration count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier: operands arrive on inbus in two
// consecutive cycles, the 2*WIDTH-bit product leaves as high word then low word.
module booth_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             busy,
  output logic             out_valid,
  output logic             done
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   a_next;
  logic [WIDTH:0]   m_ext;
  logic             q_1;
  logic             load_m;
  logic             load_q;
  logic             add_en;
  logic             shift_en;
  logic             last_iter;

  iter_cnt #(
    .LIMIT (WIDTH),
    .CW    (CW)
  ) u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (load_q),
    .inc   (shift_en),
    .tc    (last_iter)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? LOAD_M : IDLE;
      LOAD_M:  next_state = LOAD_Q;
      LOAD_Q:  next_state = ADD;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = last_iter ? OUT_HI : ADD;
      OUT_HI:  next_state = OUT_LO;
      OUT_LO:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath enables and output bus, decoded from the current state.
  always_comb begin
    load_m    = 1'b0;
    load_q    = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
    outbus    = '0;
    case (state)
      IDLE:    busy = 1'b0;
      LOAD_M:  load_m = 1'b1;
      LOAD_Q:  load_q = 1'b1;
      ADD:     add_en = 1'b1;
      SHIFT:   shift_en = 1'b1;
      OUT_HI: begin
        out_valid = 1'b1;
        outbus    = a[WIDTH-1:0];
      end
      OUT_LO: begin
        out_valid = 1'b1;
        done      = 1'b1;
        outbus    = q;
      end
      default: busy = 1'b0;
    endcase
  end

  // One extra bit on A absorbs the overflow of A - M when M is the most negative value.
  assign m_ext = {m[WIDTH-1], m};

  // Booth add/subtract decision on the current multiplier bit pair.
  always_comb begin
    a_next = a;
    case ({q[0], q_1})
      2'b01:   a_next = a + m_ext;
      2'b10:   a_next = a - m_ext;
      default: a_next = a;
    endcase
  end

  // Multiplicand, accumulator and multiplier registers (load-or-shift).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m   <= '0;
      q   <= '0;
      a   <= '0;
      q_1 <= 1'b0;
    end else begin
      if (load_m) begin
        m <= inbus;
      end
      if (load_q) begin
        q   <= inbus;
        a   <= '0;
        q_1 <= 1'b0;
      end else if (add_en) begin
        a <= a_next;
      end else if (shift_en) begin
        a   <= {a[WIDTH], a[WIDTH:1]};
        q   <= {a[0], q[WIDTH-1:1]};
        q_1 <= q[0];
      end
    end
  end

endmodule
